// File: rtl/dma_command_stager_if.sv
// Command, write-data, buffer and DMA request signals of the DMA command stager.
// slave = stager side, master = host/DMA side.
interface dma_command_stager_if #(
  parameter int BUFFER_ADDR_WIDTH = 9
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_read_n_write;
  logic [31:0]                  cmd_address;
  logic [8:0]                   cmd_length;
  logic [3:0]                   cmd_byte_enable;
  logic                         wdata_valid;
  logic                         wdata_ready;
  logic [31:0]                  wdata;
  logic [BUFFER_ADDR_WIDTH-1:0] buffer_address;
  logic                         buffer_write_enable;
  logic [31:0]                  buffer_data;
  logic                         ipcore_dataReady;
  logic                         ipcore_readReady;
  logic [31:0]                  ipcore_address;
  logic [3:0]                   ipcore_byteEnable;
  logic [8:0]                   ipcore_burst_length;
  logic                         dma_busy;
  logic                         cmd_error;

  modport slave (
    input  cmd_valid, cmd_read_n_write, cmd_address, cmd_length, cmd_byte_enable,
    input  wdata_valid, wdata, dma_busy,
    output cmd_ready, wdata_ready, buffer_address, buffer_write_enable, buffer_data,
    output ipcore_dataReady, ipcore_readReady, ipcore_address, ipcore_byteEnable,
    output ipcore_burst_length, cmd_error
  );

  modport master (
    output cmd_valid, cmd_read_n_write, cmd_address, cmd_length, cmd_byte_enable,
    output wdata_valid, wdata, dma_busy,
    input  cmd_ready, wdata_ready, buffer_address, buffer_write_enable, buffer_data,
    input  ipcore_dataReady, ipcore_readReady, ipcore_address, ipcore_byteEnable,
    input  ipcore_burst_length, cmd_error
  );
endinterface

// File: rtl/dma_command_stager.sv
// Stages host write words into the DMA buffer and issues one read/write request at a time.
// Optional FILL stall timeout: define STAGER_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | ready for a command while DMA not busy
// FILL      | taking write words into buffer
// ISSUE     | one-cycle dataReady/readReady pulse
// WAIT_BUSY | waiting up to 8 cycles for DMA to go busy
// WAIT_DONE | waiting for DMA to drop busy
module dma_command_stager #(
  parameter int BUFFER_ADDR_WIDTH = 9,
  parameter int MAX_BURST         = 256,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input logic                 clock,
  input logic                 reset,
  dma_command_stager_if.slave bus
);
  localparam int AW = BUFFER_ADDR_WIDTH;

  if (MAX_BURST > (1 << AW) || MAX_BURST < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("dma_command_stager: MAX_BURST must fit the buffer and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [8:0]    len_q, len_d;
  logic [3:0]    be_q, be_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    wait_q, wait_d;
  logic          err_q, err_d;

`ifdef STAGER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  logic cmd_ready_c, wdata_ready_c, we_c, issue_c;
  logic bad_len, last_word;

  assign bad_len   = (bus.cmd_length == 9'd0) || ({1'b0, bus.cmd_length} > 10'(MAX_BURST));
  assign last_word = (10'(cnt_q) == (10'(len_q) - 10'd1));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    be_d          = be_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    err_d         = err_q;
`ifdef STAGER_TIMEOUT_EN
    to_d          = to_q;
`endif
    cmd_ready_c   = 1'b0;
    wdata_ready_c = 1'b0;
    we_c          = 1'b0;
    issue_c       = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_c = !bus.dma_busy;
        if (bus.cmd_valid && cmd_ready_c) begin
          addr_d = bus.cmd_address;
          len_d  = bus.cmd_length;
          be_d   = bus.cmd_byte_enable;
          rd_d   = bus.cmd_read_n_write;
          cnt_d  = '0;
          err_d  = bad_len;
`ifdef STAGER_TIMEOUT_EN
          to_d   = TO_LOAD;
`endif
          if (!bad_len) state_d = bus.cmd_read_n_write ? ISSUE : FILL;
        end
      end
      FILL: begin
        wdata_ready_c = 1'b1;
        if (bus.wdata_valid) begin
          we_c  = 1'b1;
          cnt_d = cnt_q + 1'b1;
`ifdef STAGER_TIMEOUT_EN
          to_d  = TO_LOAD;
`endif
          if (last_word) state_d = ISSUE;
        end
`ifdef STAGER_TIMEOUT_EN
        else if (to_q == '0) begin
          // Stalled too long: drop the burst without telling the DMA.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q - 1'b1;
        end
`endif
      end
      ISSUE: begin
        issue_c = 1'b1;
        wait_d  = 3'd7;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.dma_busy)        state_d = WAIT_DONE;
        else if (wait_q == 3'd0) state_d = IDLE;
        else                     wait_d  = wait_q - 3'd1;
      end
      WAIT_DONE: begin
        if (!bus.dma_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Keep every strobe quiet while reset is held, whatever state we were in.
    if (reset) begin
      cmd_ready_c   = 1'b0;
      wdata_ready_c = 1'b0;
      we_c          = 1'b0;
      issue_c       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
`ifdef STAGER_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
`ifdef STAGER_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign bus.cmd_ready           = cmd_ready_c;
  assign bus.wdata_ready         = wdata_ready_c;
  assign bus.buffer_write_enable = we_c;
  assign bus.buffer_address      = we_c ? cnt_q : '0;
  assign bus.buffer_data         = we_c ? bus.wdata : '0;
  assign bus.ipcore_dataReady    = issue_c && !rd_q;
  assign bus.ipcore_readReady    = issue_c && rd_q;
  assign bus.ipcore_address      = issue_c ? addr_q : '0;
  assign bus.ipcore_byteEnable   = issue_c ? be_q : '0;
  assign bus.ipcore_burst_length = issue_c ? len_q : '0;
  assign bus.cmd_error           = err_q;
endmodule
